control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The parameter list SHALL be: OPW, 6, opcode field width (instruction bits 31:26); only 6 is supported.
REQ-002 The clock and reset SHALL be: clk  input  1  sole clock, all state updates on its rising edge; reset  input  1  synchronous, active-high.
REQ-003 The opcode port SHALL be: opcode  input  OPW  instruction opcode.
REQ-004 The instr_valid port SHALL be: instr_valid  input  1  opcode is a real instruction.
REQ-005 The stall port SHALL be: stall  input  1  hold the registered outputs.
REQ-006 The flush port SHALL be: flush  input  1  replace the next registered output with a bubble.
REQ-007 The decoded outputs SHALL be: RegDst, Branch, MemRead, MemtoReg, MemWrite, AluSrc, RegWrite  output  1 each  datapath controls.
REQ-008 The AluOp port SHALL be: AluOp  output  2  ALU class (00 add, 01 subtract/compare, 10 use funct field).
REQ-009 The status outputs SHALL be: illegal_op  output  1  unsupported opcode; valid_out  output  1  registered outputs are a real instruction.

Function
REQ-010 Decode SHALL be combinational from opcode and feed one output register stage, giving 1-cycle latency from opcode to outputs.
REQ-011 R-type, opcode 0x00, SHALL decode to RegDst=1, RegWrite=1, AluOp=10, all other controls 0.
REQ-012 lw, opcode 0x23, SHALL decode to AluSrc=1, MemtoReg=1, RegWrite=1, MemRead=1, AluOp=00, all other controls 0.
REQ-013 sw, opcode 0x2B, SHALL decode to AluSrc=1, MemWrite=1, AluOp=00, all other controls 0; RegDst and MemtoReg are driven 0, not don't-care.
REQ-014 beq, opcode 0x04, SHALL decode to Branch=1, AluOp=01, all other controls 0.
REQ-015 Any other opcode SHALL decode to all controls 0, AluOp=00 and illegal_op=1.
REQ-016 With instr_valid=0, the decode SHALL be forced to all controls 0 and illegal_op=0.
REQ-017 valid_out SHALL register instr_valid, so it is 1 only when the stage holds a valid instruction.
REQ-018 Per-edge priority SHALL be reset > flush > stall > load.
REQ-019 Flush SHALL load all outputs to 0, including valid_out and illegal_op, even when stall is also 1.
REQ-020 Stall without flush SHALL hold every output unchanged, including illegal_op and valid_out.
REQ-021 Outputs SHALL never present a store and a register write at the same time.
REQ-022 MemRead and MemWrite SHALL be mutually exclusive in every state.

Reset
REQ-023 With reset=1 at a rising clk edge, every output SHALL become 0 on that edge.
REQ-024 Reset SHALL override flush and stall in the same cycle.
REQ-025 The first load SHALL occur on the first edge with reset=0.

Configuration
REQ-026 With macro CU_ADDI_EN defined, addi, opcode 0x08, SHALL decode to AluSrc=1, RegWrite=1, AluOp=00, all other controls 0, illegal_op=0.
REQ-027 With CU_ADDI_EN undefined, opcode 0x08 SHALL decode as illegal per REQ-015.

Structure
REQ-028 Package cu_pkg SHALL hold:
- opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI;
- AluOp constants ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT;
- a packed control-bundle typedef.
REQ-029 The purely combinational decode SHALL be the single sub-module cu_decoder; control_unit holds only the register stage and priority logic.

Verification
REQ-030 Reset: reset=1 for 2 cycles with opcode=0x23, instr_valid=1 -> all outputs 0; first edge after release -> MemRead=1, MemtoReg=1, RegWrite=1, AluSrc=1.
REQ-031 Opcode sweep 0x00, 0x23, 0x2B, 0x04 with instr_valid=1 -> exactly the REQ-011 to REQ-014 vectors one cycle later, valid_out=1, illegal_op=0.
REQ-032 Illegal opcode 0x3F with instr_valid=1 -> all controls 0, illegal_op=1, valid_out=1; same opcode with instr_valid=0 -> illegal_op=0, valid_out=0.
REQ-033 Stall: load 0x04, raise stall, change opcode to 0x00 for 3 cycles -> Branch=1, AluOp=01 held; release stall -> RegDst=1, AluOp=10 next cycle.
REQ-034 Flush with stall: stall=1, flush=1 while holding lw -> all outputs 0 next cycle.
REQ-035 Macro: opcode 0x08 -> AluSrc=1, RegWrite=1 with CU_ADDI_EN defined; illegal_op=1 and all controls 0 without it.

Source files
------------

// File: rtl/cu_pkg.sv
// cu_pkg: shared definitions for the control unit.
//   - opcode constants for the supported instructions
//   - AluOp class constants
//   - ctrl_t: packed bundle of the decoded datapath controls plus illegal_op
package cu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
        logic       illegal_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/cu_decoder.sv
// cu_decoder: purely combinational opcode decode.
// Ports:
//   opcode      [OPW-1:0] instruction opcode (bits 31:26)
//   instr_valid           opcode is a real instruction; when 0 the decode is all zero
//   ctrl        ctrl_t    decoded control bundle including illegal_op
// Optional feature: define CU_ADDI_EN to decode addi (0x08); otherwise 0x08 is illegal.
module cu_decoder
    import cu_pkg::*;
#(
    parameter int unsigned OPW = 6  // only 6 is supported
) (
    input  logic [OPW-1:0] opcode,
    input  logic           instr_valid,
    output ctrl_t          ctrl
);

    always_comb begin
        ctrl = CTRL_NOP;
        if (instr_valid) begin
            case (opcode)
                OP_RTYPE: begin
                    ctrl.reg_dst   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = ALUOP_FUNCT;
                end
                OP_LW: begin
                    ctrl.alu_src    = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_read   = 1'b1;
                    ctrl.alu_op     = ALUOP_ADD;
                end
                OP_SW: begin
                    // RegDst/MemtoReg stay at their 0 default, never don't-care
                    ctrl.alu_src   = 1'b1;
                    ctrl.mem_write = 1'b1;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                OP_BEQ: begin
                    ctrl.branch = 1'b1;
                    ctrl.alu_op = ALUOP_SUB;
                end
`ifdef CU_ADDI_EN
                OP_ADDI: begin
                    ctrl.alu_src   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = ALUOP_ADD;
                end
`endif
                default: begin
                    ctrl.illegal_op = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: registered instruction control decode (1-cycle latency).
// Ports:
//   clk, reset          sole clock; synchronous active-high reset
//   opcode [OPW-1:0]    instruction opcode
//   instr_valid         opcode is a real instruction
//   stall               hold all registered outputs
//   flush               load a bubble (all zero), overrides stall
//   RegDst, Branch, MemRead, MemtoReg, MemWrite, AluSrc, RegWrite, AluOp[1:0]
//                       registered datapath controls
//   illegal_op          registered: opcode was unsupported
//   valid_out           registered instr_valid
// Edge priority: reset > flush > stall > load.
// Optional feature: CU_ADDI_EN enables addi decode inside cu_decoder.
module control_unit
    import cu_pkg::*;
#(
    parameter int unsigned OPW = 6  // only 6 is supported
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           instr_valid,
    input  logic           stall,
    input  logic           flush,
    output logic           RegDst,
    output logic           Branch,
    output logic           MemRead,
    output logic           MemtoReg,
    output logic           MemWrite,
    output logic           AluSrc,
    output logic           RegWrite,
    output logic [1:0]     AluOp,
    output logic           illegal_op,
    output logic           valid_out
);

    ctrl_t ctrl_dec;
    ctrl_t ctrl_d, ctrl_q;
    logic  valid_d, valid_q;

    cu_decoder #(
        .OPW(OPW)
    ) u_decoder (
        .opcode     (opcode),
        .instr_valid(instr_valid),
        .ctrl       (ctrl_dec)
    );

    always_comb begin
        ctrl_d  = ctrl_dec;
        valid_d = instr_valid;
        if (flush) begin
            ctrl_d  = CTRL_NOP;
            valid_d = 1'b0;
        end else if (stall) begin
            ctrl_d  = ctrl_q;
            valid_d = valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= CTRL_NOP;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

    assign RegDst     = ctrl_q.reg_dst;
    assign Branch     = ctrl_q.branch;
    assign MemRead    = ctrl_q.mem_read;
    assign MemtoReg   = ctrl_q.mem_to_reg;
    assign MemWrite   = ctrl_q.mem_write;
    assign AluSrc     = ctrl_q.alu_src;
    assign RegWrite   = ctrl_q.reg_write;
    assign AluOp      = ctrl_q.alu_op;
    assign illegal_op = ctrl_q.illegal_op;
    assign valid_out  = valid_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the driver pushes one expected output
// vector per driven cycle; the monitor pops and compares one cycle later.
// Vector order: {RegDst,Branch,MemRead,MemtoReg,MemWrite,AluSrc,RegWrite,AluOp,illegal_op,valid_out}
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       instr_valid = 1'b0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic       RegDst, Branch, MemRead, MemtoReg, MemWrite, AluSrc, RegWrite;
    logic [1:0] AluOp;
    logic       illegal_op, valid_out;

    control_unit #(
        .OPW(6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .instr_valid(instr_valid),
        .stall      (stall),
        .flush      (flush),
        .RegDst     (RegDst),
        .Branch     (Branch),
        .MemRead    (MemRead),
        .MemtoReg   (MemtoReg),
        .MemWrite   (MemWrite),
        .AluSrc     (AluSrc),
        .RegWrite   (RegWrite),
        .AluOp      (AluOp),
        .illegal_op (illegal_op),
        .valid_out  (valid_out)
    );

    always #5 clk = ~clk;

    localparam logic [10:0] V_ZERO  = 11'b0000000_00_0_0;
    localparam logic [10:0] V_RTYPE = 11'b1000001_10_0_1;
    localparam logic [10:0] V_LW    = 11'b0011011_00_0_1;
    localparam logic [10:0] V_SW    = 11'b0000110_00_0_1;
    localparam logic [10:0] V_BEQ   = 11'b0100000_01_0_1;
    localparam logic [10:0] V_ILL   = 11'b0000000_00_1_1;
`ifdef CU_ADDI_EN
    localparam logic [10:0] V_ADDI  = 11'b0000011_00_0_1;
`else
    localparam logic [10:0] V_ADDI  = V_ILL;
`endif

    typedef struct {
        logic [10:0] exp;
        string       name;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_fail = 0;

    task automatic drive(input string name, input logic r, input logic s, input logic f,
                         input logic v, input logic [5:0] op, input logic [10:0] exp);
        sb_t e;
        @(negedge clk);
        reset       = r;
        stall       = s;
        flush       = f;
        instr_valid = v;
        opcode      = op;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Monitor: each loading edge, compare the oldest expectation
    initial begin
        sb_t         e;
        logic [10:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {RegDst, Branch, MemRead, MemtoReg, MemWrite, AluSrc, RegWrite,
                       AluOp, illegal_op, valid_out};
                n_cmp++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %b required %b", e.name, act, e.exp);
                end
                n_cmp++;
                if ((MemRead && MemWrite) || (MemWrite && RegWrite)) begin
                    n_fail++;
                    $display("FAIL %s_exclusive: MemRead=%b MemWrite=%b RegWrite=%b required no overlap",
                             e.name, MemRead, MemWrite, RegWrite);
                end
            end
        end
    end

    initial begin
        // reset held for 2 cycles with lw present
        drive("rst0", 1, 0, 0, 1, 6'h23, V_ZERO);
        drive("rst1", 1, 0, 0, 1, 6'h23, V_ZERO);
        drive("first_load_lw", 0, 0, 0, 1, 6'h23, V_LW);
        // opcode sweep
        drive("rtype", 0, 0, 0, 1, 6'h00, V_RTYPE);
        drive("lw", 0, 0, 0, 1, 6'h23, V_LW);
        drive("sw", 0, 0, 0, 1, 6'h2B, V_SW);
        drive("beq", 0, 0, 0, 1, 6'h04, V_BEQ);
        // illegal opcode, valid and invalid
        drive("ill_valid", 0, 0, 0, 1, 6'h3F, V_ILL);
        drive("ill_invalid", 0, 0, 0, 0, 6'h3F, V_ZERO);
        drive("invalid_lw", 0, 0, 0, 0, 6'h23, V_ZERO);
        // stall holds beq while opcode changes
        drive("stall_load_beq", 0, 0, 0, 1, 6'h04, V_BEQ);
        drive("stall_hold0", 0, 1, 0, 1, 6'h00, V_BEQ);
        drive("stall_hold1", 0, 1, 0, 1, 6'h00, V_BEQ);
        drive("stall_hold2", 0, 1, 0, 1, 6'h00, V_BEQ);
        drive("stall_release", 0, 0, 0, 1, 6'h00, V_RTYPE);
        // stall holds illegal_op and valid_out
        drive("ill_load", 0, 0, 0, 1, 6'h3F, V_ILL);
        drive("ill_hold", 0, 1, 0, 0, 6'h00, V_ILL);
        // flush beats stall
        drive("flush_load_lw", 0, 0, 0, 1, 6'h23, V_LW);
        drive("flush_stall", 0, 1, 1, 1, 6'h23, V_ZERO);
        drive("hold_bubble", 0, 1, 0, 1, 6'h23, V_ZERO);
        drive("flush_only", 0, 0, 1, 1, 6'h00, V_ZERO);
        // reset beats flush and stall
        drive("pre_rst_lw", 0, 0, 0, 1, 6'h23, V_LW);
        drive("rst_over_all", 1, 1, 1, 1, 6'h00, V_ZERO);
        // configurable addi
        drive("addi", 0, 0, 0, 1, 6'h08, V_ADDI);
        drive("sw_after", 0, 0, 0, 1, 6'h2B, V_SW);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
